// File: rtl/spio_link_status_monitor.sv
// Per-device link status conditioner: synchronises and debounces link-up, stretches
// error events into held indications, and turns packet handshakes into activity pulses.
module spio_link_status_monitor #(
  parameter int unsigned NUM_DEVICES       = 1,
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned DEBOUNCE_BITS     = 20,
  parameter int unsigned ERROR_HOLD_CYCLES = 75000000,
  parameter int unsigned ERROR_HOLD_BITS   = 27
) (
  input  logic                   CLK_IN,
  input  logic                   RESET_IN,
  input  logic [NUM_DEVICES-1:0] LINK_UP_IN,
  input  logic [NUM_DEVICES-1:0] ERROR_PULSE_IN,
  input  logic [NUM_DEVICES-1:0] PKT_VLD_IN,
  input  logic [NUM_DEVICES-1:0] PKT_RDY_IN,
  output logic [NUM_DEVICES-1:0] ERROR_OUT,
  output logic [NUM_DEVICES-1:0] CONNECTED_OUT,
  output logic [NUM_DEVICES-1:0] ACTIVITY_OUT,
  output logic                   ANY_ERROR_OUT
);

  localparam logic [1:0] ST_DOWN       = 2'd0;
  localparam logic [1:0] ST_GOING_UP   = 2'd1;
  localparam logic [1:0] ST_UP         = 2'd2;
  localparam logic [1:0] ST_GOING_DOWN = 2'd3;

  localparam logic [DEBOUNCE_BITS-1:0]   DB_LOAD = DEBOUNCE_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEBOUNCE_BITS-1:0]   DB_ONE  = DEBOUNCE_BITS'(1);
  localparam logic [ERROR_HOLD_BITS-1:0] EH_LOAD = ERROR_HOLD_BITS'(ERROR_HOLD_CYCLES);
  localparam logic [ERROR_HOLD_BITS-1:0] EH_ONE  = ERROR_HOLD_BITS'(1);

  logic [NUM_DEVICES-1:0] w_error;
  logic [NUM_DEVICES-1:0] w_connected;
  logic [NUM_DEVICES-1:0] w_activity;
  logic                   r_any_error;

  for (genvar g = 0; g < NUM_DEVICES; g++) begin : g_dev
    logic                       r_sync1;
    logic                       r_sync2;
    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic [DEBOUNCE_BITS-1:0]   r_cnt;
    logic [DEBOUNCE_BITS-1:0]   w_cnt_nxt;
    logic [ERROR_HOLD_BITS-1:0] r_hold;
    logic [ERROR_HOLD_BITS-1:0] w_hold_nxt;
    logic                       w_link_loss;
    logic                       w_conn_nxt;
    logic                       w_act_nxt;
    logic                       r_conn;
    logic                       r_error;
    logic                       r_act;

    // Debounce next-state, error-hold and activity next values
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_link_loss = 1'b0;
      w_hold_nxt  = r_hold;
      case (r_state)
        ST_DOWN: begin
          if (r_sync2) begin
            w_state_nxt = ST_GOING_UP;
            w_cnt_nxt   = DB_LOAD;
          end
        end
        ST_GOING_UP: begin
          if (!r_sync2)           w_state_nxt = ST_DOWN;
          else if (r_cnt == '0)   w_state_nxt = ST_UP;
          else                    w_cnt_nxt   = r_cnt - DB_ONE;
        end
        ST_UP: begin
          if (!r_sync2) begin
            w_state_nxt = ST_GOING_DOWN;
            w_cnt_nxt   = DB_LOAD;
          end
        end
        ST_GOING_DOWN: begin
          if (r_sync2) begin
            w_state_nxt = ST_UP;
          end else if (r_cnt == '0) begin
            w_state_nxt = ST_DOWN;
            w_link_loss = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - DB_ONE;
          end
        end
        default: w_state_nxt = ST_DOWN;
      endcase

      w_conn_nxt = (w_state_nxt == ST_UP) || (w_state_nxt == ST_GOING_DOWN);

      // Retriggerable hold; a coincident pulse and link loss is a single load
      if (ERROR_PULSE_IN[g] || w_link_loss) w_hold_nxt = EH_LOAD;
      else if (r_hold != '0)                w_hold_nxt = r_hold - EH_ONE;

      w_act_nxt = PKT_VLD_IN[g] & PKT_RDY_IN[g] & r_conn;
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_state <= ST_DOWN;
        r_cnt   <= '0;
        r_hold  <= '0;
        r_conn  <= 1'b0;
        r_error <= 1'b0;
        r_act   <= 1'b0;
      end else begin
        r_sync1 <= LINK_UP_IN[g];
        r_sync2 <= r_sync1;
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_hold  <= w_hold_nxt;
        r_conn  <= w_conn_nxt;
        r_error <= (w_hold_nxt != '0);
        r_act   <= w_act_nxt;
      end
    end

    assign w_error[g]     = r_error;
    assign w_connected[g] = r_conn;
    assign w_activity[g]  = r_act;
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) r_any_error <= 1'b0;
    else          r_any_error <= |w_error;
  end

  assign ERROR_OUT     = w_error;
  assign CONNECTED_OUT = w_connected;
  assign ACTIVITY_OUT  = w_activity;
  assign ANY_ERROR_OUT = r_any_error;

endmodule

// File: tb/tb_spio_link_status_monitor.sv
// Directed self-checking bench for spio_link_status_monitor (2 devices, debounce 4, hold 8).
module tb_spio_link_status_monitor;

  logic       clk;
  logic       rst;
  logic [1:0] link_up;
  logic [1:0] err_pulse;
  logic [1:0] vld;
  logic [1:0] rdy;
  logic [1:0] error_o;
  logic [1:0] conn_o;
  logic [1:0] act_o;
  logic       any_o;

  int n_tests = 0;
  int n_fail  = 0;

  spio_link_status_monitor #(
    .NUM_DEVICES      (2),
    .DEBOUNCE_CYCLES  (4),
    .DEBOUNCE_BITS    (4),
    .ERROR_HOLD_CYCLES(8),
    .ERROR_HOLD_BITS  (4)
  ) dut (
    .CLK_IN        (clk),
    .RESET_IN      (rst),
    .LINK_UP_IN    (link_up),
    .ERROR_PULSE_IN(err_pulse),
    .PKT_VLD_IN    (vld),
    .PKT_RDY_IN    (rdy),
    .ERROR_OUT     (error_o),
    .CONNECTED_OUT (conn_o),
    .ACTIVITY_OUT  (act_o),
    .ANY_ERROR_OUT (any_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    link_up   = 2'b00;
    err_pulse = 2'b00;
    vld       = 2'b00;
    rdy       = 2'b00;
    rst       = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
  endtask

  task automatic test_reset_and_connect();
    do_reset();
    n_tests++;
    if ({error_o, conn_o, act_o, any_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000000", {error_o, conn_o, act_o, any_o});
    end
    link_up = 2'b01;
    for (int k = 0; k <= 7; k++) begin
      step();
      n_tests++;
      if (conn_o !== ((k >= 6) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL connect_edge%0d: got %b expected %b", k, conn_o, (k >= 6) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    link_up = 2'b01;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 2) link_up = 2'b00;
      n_tests++;
      if (conn_o !== 2'b00 || error_o !== 2'b00) begin
        n_fail++;
        $display("FAIL glitch_edge%0d: conn %b err %b expected 00 00", k, conn_o, error_o);
      end
    end
  endtask

  task automatic test_link_loss();
    logic [1:0] exp_conn;
    logic [1:0] exp_err;
    logic       exp_any;
    do_reset();
    link_up = 2'b01;
    for (int k = 0; k < 7; k++) step();
    n_tests++;
    if (conn_o !== 2'b01) begin
      n_fail++;
      $display("FAIL loss_pre_connected: got %b expected 01", conn_o);
    end
    link_up = 2'b00;
    for (int k = 0; k <= 16; k++) begin
      step();
      exp_conn = (k < 6) ? 2'b01 : 2'b00;
      exp_err  = (k >= 6 && k <= 13) ? 2'b01 : 2'b00;
      exp_any  = (k >= 7 && k <= 14);
      n_tests++;
      if (conn_o !== exp_conn || error_o !== exp_err || any_o !== exp_any) begin
        n_fail++;
        $display("FAIL loss_edge%0d: conn %b err %b any %b expected %b %b %b",
                 k, conn_o, error_o, any_o, exp_conn, exp_err, exp_any);
      end
    end
  endtask

  task automatic test_error_retrigger();
    logic [1:0] exp_err;
    logic       exp_any;
    do_reset();
    err_pulse = 2'b10;
    for (int n = 1; n <= 16; n++) begin
      step();
      err_pulse = (n == 5) ? 2'b10 : 2'b00;
      exp_err = (n >= 1 && n <= 13) ? 2'b10 : 2'b00;
      exp_any = (n >= 2 && n <= 14);
      n_tests++;
      if (error_o !== exp_err || any_o !== exp_any) begin
        n_fail++;
        $display("FAIL retrig_edge%0d: err %b any %b expected %b %b", n, error_o, any_o, exp_err, exp_any);
      end
    end
  endtask

  task automatic test_activity();
    logic [1:0] exp_act;
    do_reset();
    link_up = 2'b01;
    for (int k = 0; k < 7; k++) step();
    vld = 2'b11;
    rdy = 2'b11;
    for (int n = 1; n <= 6; n++) begin
      step();
      if (n == 3) begin
        vld = 2'b11;
        rdy = 2'b00;
      end else if (n >= 4) begin
        vld = 2'b00;
      end
      exp_act = (n <= 3) ? 2'b01 : 2'b00;
      n_tests++;
      if (act_o !== exp_act) begin
        n_fail++;
        $display("FAIL activity_edge%0d: got %b expected %b", n, act_o, exp_act);
      end
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    link_up   = 2'b01;
    err_pulse = 2'b10;
    step();
    err_pulse = 2'b00;
    step();
    step();
    n_tests++;
    if (error_o !== 2'b10 || conn_o !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_pre: err %b conn %b expected 10 00", error_o, conn_o);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({error_o, conn_o, act_o, any_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL midrst_async_clear: got %b expected 0000000", {error_o, conn_o, act_o, any_o});
    end
    #2 rst = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      step();
      n_tests++;
      if (conn_o !== ((k >= 6) ? 2'b01 : 2'b00) || error_o !== 2'b00) begin
        n_fail++;
        $display("FAIL midrst_edge%0d: conn %b err %b expected %b 00",
                 k, conn_o, error_o, (k >= 6) ? 2'b01 : 2'b00);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    link_up   = 2'b00;
    err_pulse = 2'b00;
    vld       = 2'b00;
    rdy       = 2'b00;
    test_reset_and_connect();
    test_glitch();
    test_link_loss();
    test_error_retrigger();
    test_activity();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
